regfile_multiport: RTL
======================

// Module: regfile_multiport
// PURPOSE
//  Parametrised multi-port CPU register file; next generation of the single-write, dual-read bank.
//  Width, depth, read-port count and write-port count are configurable.
//  After reset, a clear sequencer initialises the bank one entry per cycle.
//  Sits in decode (reads) and writeback (writes) of the MIPS datapath. Ready gates issue.
// PARAMETERS
//  DATA_W      32               data width per entry
//  DEPTH       32               number of entries (>=2)
//  ADDR_W      $clog2(DEPTH)    address width
//  NUM_RD      2                combinational read ports (>=1)
//  NUM_WR      1                write ports (1..4)
//  ZERO_REG    1                1: entry 0 hardwired to zero (writes dropped, reads return 0)
//  INIT_INDEX  1                1: init writes entry i <= i; 0: init writes 0
// PORTS
//  Clk         in   1                 clock, all state on posedge
//  Reset       in   1                 synchronous, active-high
//  RdAddr      in   NUM_RD*ADDR_W     read addresses, port p at [p*ADDR_W +: ADDR_W]
//  RdData      out  NUM_RD*DATA_W     read data, port p at [p*DATA_W +: DATA_W]
//  WrEn        in   NUM_WR            write enables
//  WrAddr      in   NUM_WR*ADDR_W     write addresses
//  WrData      in   NUM_WR*DATA_W     write data
//  Ready       out  1                 1 = init complete, bank accepts writes
//  WrDropped   out  1                 1-cycle pulse: a WrEn was asserted while Ready=0
// BEHAVIOUR
//  Reset: one clock, synchronous, active-high. While Reset is high:
//    - FSM=CLEAR, clear counter=0, Ready=0, WrDropped=0.
//    - Array contents are not touched in the Reset cycle itself.
//  CLEAR state: each cycle, writes bank[cnt] <= (INIT_INDEX ? cnt : 0), zero-extended to DATA_W; then cnt++.
//    After writing cnt==DEPTH-1: FSM=RUN, Ready=1 on the next edge.
//    Ready therefore rises exactly DEPTH cycles after the first cycle with Reset low.
//  Reset asserted mid-CLEAR or in RUN: restarts CLEAR from cnt=0. Contents are rewritten; no partial state survives.
//  While Ready=0:
//    - RdData=0 on all ports.
//    - Any WrEn is ignored; WrDropped=1 on the following cycle.
//  RUN state, writes:
//    - Port p commits bank[WrAddr_p] <= WrData_p at posedge when WrEn[p]=1.
//    - Exception: no commit if ZERO_REG=1 and WrAddr_p==0.
//  Same-cycle write conflict (same address on two ports): highest port index wins. Other ports' data discarded.
//  Reads are combinational: RdData_p = bank[RdAddr_p]. Returns 0 if ZERO_REG and RdAddr_p==0.
//  Read-during-write, same address: returns the old value (no forwarding) unless REGFILE_BYPASS_EN is set.
//  Out-of-range address (DEPTH not a power of 2):
//    - Read returns 0.
//    - Write is dropped silently (no WrDropped).
//  No other latency: write-to-read visibility is 1 cycle.
// CONFIGURATION
//  Macro REGFILE_BYPASS_EN.
//  Defined:
//    - Each read port compares RdAddr_p against every enabled write port in the same cycle.
//    - On a match, returns that WrData combinationally. Highest matching port wins.
//    - ZERO_REG still forces 0 for address 0. Bypass is inactive while Ready=0.
//    - Write-to-read latency becomes 0 cycles.
//  Undefined: no comparators; behaviour as above (old value in the write cycle).
// STRUCTURE
//  Package regfile_pkg:
//    - state typedef {RF_CLEAR, RF_RUN}
//    - RF_MAX_WR=4
//    - function clog2 for ADDR_W
//  Sub-module regfile_clear_seq:
//    - Owns the FSM, clear counter, Ready and WrDropped.
//    - Exports ClrEn, ClrAddr, ClrData to the bank write mux. ClrEn has priority over all user write ports.
//  Top: storage array, write-port priority mux, read muxes, optional bypass network.
// TESTING
//  1. Reset 1 cycle, DEPTH=32 -> Ready=0 for 32 cycles then 1; reading addr 5 returns 5 (INIT_INDEX=1).
//  2. WrEn[0]=1 addr 3 data 0xDEADBEEF during CLEAR -> WrDropped=1 next cycle; after Ready, addr 3 reads 3.
//  3. RUN, NUM_WR=2, both ports write addr 7 (0x11, 0x22) -> addr 7 reads 0x22; write 0xFF to addr 0 -> reads 0.
//  4. RUN, write addr 9=0xA5A5 with RdAddr=9 same cycle -> old value 9 without REGFILE_BYPASS_EN, 0xA5A5 with it; 0xA5A5 next cycle in both builds.
//  5. Reset asserted at clear cnt=10 -> cnt restarts at 0; Ready rises 32 cycles after Reset drops; all entries hold init values.
//  6. DEPTH=24, NUM_RD=4: read addr 30 -> 0; write addr 30 -> no effect, no WrDropped; other ports unaffected.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

    localparam int RF_MAX_WR = 4;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks the bank one entry per cycle, then raises Ready.
// Also flags user writes that arrive before the bank is ready.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = clog2(DEPTH),
    parameter int NUM_WR     = 1,
    parameter int INIT_INDEX = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NUM_WR-1:0] WrEn,
    output logic              Ready,
    output logic              WrDropped,
    output logic              ClrEn,
    output logic [ADDR_W-1:0] ClrAddr,
    output logic [DATA_W-1:0] ClrData
);

    rf_state_t         state;
    rf_state_t         state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic              dropped_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= RF_CLEAR;
            cnt       <= '0;
            WrDropped <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            WrDropped <= dropped_next;
        end
    end

    // The reset cycle itself must leave the array alone, hence ClrEn is masked by Reset.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        ClrEn        = 1'b0;
        dropped_next = (state != RF_RUN) && (|WrEn);
        if (state == RF_CLEAR) begin
            ClrEn = !Reset;
            if (cnt == ADDR_W'(DEPTH - 1)) begin
                state_next = RF_RUN;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt + ADDR_W'(1);
            end
        end
    end

    assign Ready   = (state == RF_RUN);
    assign ClrAddr = cnt;
    assign ClrData = (INIT_INDEX != 0) ? DATA_W'(cnt) : '0;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file with post-reset clear sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = clog2(DEPTH),
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1,
    parameter int INIT_INDEX = 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    input  logic [NUM_WR-1:0]        WrEn,
    input  logic [NUM_WR*ADDR_W-1:0] WrAddr,
    input  logic [NUM_WR*DATA_W-1:0] WrData,
    output logic                     Ready,
    output logic                     WrDropped
);

    if (NUM_WR < 1 || NUM_WR > RF_MAX_WR) begin : g_bad_num_wr
        $error("regfile_multiport: NUM_WR out of range");
    end

    logic [DATA_W-1:0] bank [DEPTH];

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;

    logic [ADDR_W-1:0] wr_addr [NUM_WR];
    logic [DATA_W-1:0] wr_data [NUM_WR];
    logic [NUM_WR-1:0] wr_commit;

    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_val;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return int'(addr) < DEPTH;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    regfile_clear_seq #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .NUM_WR     (NUM_WR),
        .INIT_INDEX (INIT_INDEX)
    ) u_clear_seq (
        .Clk       (Clk),
        .Reset     (Reset),
        .WrEn      (WrEn),
        .Ready     (Ready),
        .WrDropped (WrDropped),
        .ClrEn     (clr_en),
        .ClrAddr   (clr_addr),
        .ClrData   (clr_data)
    );

    // Out-of-range and zero-register writes are dropped silently, without WrDropped.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            wr_addr[p]   = WrAddr[p*ADDR_W +: ADDR_W];
            wr_data[p]   = WrData[p*DATA_W +: DATA_W];
            wr_commit[p] = WrEn[p] && Ready && !Reset
                           && in_range(wr_addr[p]) && !is_zero_reg(wr_addr[p]);
        end
    end

    // Later loop iterations override earlier ones, so the highest port wins a conflict.
    always_ff @(posedge Clk) begin
        if (clr_en) begin
            bank[clr_addr] <= clr_data;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_commit[p]) begin
                    bank[wr_addr[p]] <= wr_data[p];
                end
            end
        end
    end

    always_comb begin
        RdData  = '0;
        rd_addr = '0;
        rd_val  = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr = RdAddr[p*ADDR_W +: ADDR_W];
            rd_val  = '0;
            if (Ready && in_range(rd_addr) && !is_zero_reg(rd_addr)) begin
                rd_val = bank[rd_addr];
`ifdef REGFILE_BYPASS_EN
                for (int q = 0; q < NUM_WR; q++) begin
                    if (WrEn[q] && (wr_addr[q] == rd_addr)) begin
                        rd_val = wr_data[q];
                    end
                end
`endif
            end
            RdData[p*DATA_W +: DATA_W] = rd_val;
        end
    end

endmodule
